// File: rtl/uart_rx_os16.sv
// 16x-oversampling 8N1 UART receiver with majority-vote sampling and a one-entry holding register.
// Define UART_RX_PARITY_EN to add an even-parity bit and the o_Parity_Err port.
module uart_rx_os16 #(
    parameter int FPGA_clk_freq = 50000000,
    parameter int baudrate      = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_RX_Serial,
    input  logic       i_RX_Ready,
    output logic [7:0] o_RX_Byte,
    output logic       o_RX_DV,
    output logic       o_RX_Busy,
    output logic       o_Frame_Err,
`ifdef UART_RX_PARITY_EN
    output logic       o_Parity_Err,
`endif
    output logic       o_Overrun
);

    localparam int CPT = FPGA_clk_freq / (baudrate * 16);
    localparam int TW  = (CPT > 1) ? $clog2(CPT) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(CPT - 1);

    generate
        if (CPT < 1) begin : g_cfg_err
            $error("uart_rx_os16: clock too slow for 16x oversampling");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic          s1_q, s2_q, prev_q;
    logic [TW-1:0] tcnt_q;
    logic [3:0]    sub_q;
    logic [1:0]    samp_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic [7:0]    byte_q;
    logic          dv_q, fe_q, ov_q;

    logic tick, fall, maj, mid, bit_end;
    logic start_det, shift_en, stop_chk;
    logic par_bad, frame_ok, frame_err, par_err, pop;

    assign tick    = (tcnt_q == TICK_LAST);
    assign fall    = prev_q & ~s2_q;
    assign mid     = tick && (sub_q == 4'd9);
    assign bit_end = tick && (sub_q == 4'd15);
    // Tick-9 decision: two stored samples plus the live one.
    assign maj = (samp_q[0] & samp_q[1]) | (samp_q[0] & s2_q) | (samp_q[1] & s2_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (fall) state_d = START;
            START: begin
                if (mid && maj)   state_d = IDLE;
                else if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end && bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (bit_end) state_d = STOP;
`endif
            STOP:  if (mid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        start_det = (state_q == IDLE) && fall;
        shift_en  = (state_q == DATA) && mid;
        stop_chk  = (state_q == STOP) && mid;
    end

`ifdef UART_RX_PARITY_EN
    logic par_bad_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            par_bad_q <= 1'b0;
        else if (start_det)
            par_bad_q <= 1'b0;
        else if (state_q == PARITY && mid)
            par_bad_q <= maj ^ (^shift_q);
    end

    assign par_bad = par_bad_q;
`else
    assign par_bad = 1'b0;
`endif

    assign pop       = dv_q & i_RX_Ready;
    assign frame_err = stop_chk & ~maj;
    assign par_err   = stop_chk & maj & par_bad;
    assign frame_ok  = stop_chk & maj & ~par_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            prev_q  <= 1'b1;
            tcnt_q  <= '0;
            sub_q   <= 4'd0;
            samp_q  <= 2'b11;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
        end else begin
            s1_q   <= i_RX_Serial;
            s2_q   <= s1_q;
            prev_q <= s2_q;
            if (start_det || tick) tcnt_q <= '0;
            else                   tcnt_q <= tcnt_q + 1'b1;
            if (start_det) sub_q <= 4'd0;
            else if (tick) sub_q <= sub_q + 4'd1;
            if (tick && sub_q == 4'd7) samp_q[0] <= s2_q;
            if (tick && sub_q == 4'd8) samp_q[1] <= s2_q;
            if (start_det)
                bit_q <= 3'd0;
            else if (state_q == DATA && bit_end)
                bit_q <= bit_q + 3'd1;
            if (shift_en) shift_q <= {maj, shift_q[7:1]};
        end
    end

    // Holding register: a pop in the same cycle frees the slot for the new byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_q <= 8'h00;
            dv_q   <= 1'b0;
            fe_q   <= 1'b0;
            ov_q   <= 1'b0;
        end else begin
            if (frame_ok && (!dv_q || pop)) begin
                byte_q <= shift_q;
                dv_q   <= 1'b1;
            end else if (pop) begin
                dv_q   <= 1'b0;
            end
            fe_q <= frame_err;
            ov_q <= frame_ok & dv_q & ~pop;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic pe_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pe_q <= 1'b0;
        else        pe_q <= par_err;
    end

    assign o_Parity_Err = pe_q;
`else
    logic unused_par;
    assign unused_par = par_err;
`endif

    assign o_RX_Byte   = byte_q;
    assign o_RX_DV     = dv_q;
    assign o_RX_Busy   = (state_q != IDLE);
    assign o_Frame_Err = fe_q;
    assign o_Overrun   = ov_q;

endmodule
